// File: rtl/rv_decode_stage.sv
// RV32I decode stage: combinational decode of the incoming beat, then a
// 1- or 2-entry elastic buffer with valid/ready handshake and flush.
module rv_decode_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned EN_CSR  = 1,
  parameter int unsigned EN_MEXT = 0,
  parameter int unsigned SKID    = 1,
  localparam int unsigned FLAG_W = 48 + 8 * EN_MEXT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [FLAG_W-1:0] out_flags,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_illegal
);

  localparam int unsigned
    F_BNE = 47, F_BLTU = 46, F_BLT = 45, F_BGEU = 44, F_BGE = 43, F_BEQ = 42,
    F_ADDI = 41, F_SLTI = 40, F_SLTIU = 39, F_XORI = 38, F_ORI = 37, F_ANDI = 36,
    F_SLLI = 35, F_SRLI = 34, F_SRAI = 33,
    F_ADD = 32, F_SUB = 31, F_SLL = 30, F_SLT = 29, F_SLTU = 28, F_XOR = 27, F_OR = 26, F_AND = 25,
    F_LB = 24, F_LH = 23, F_LW = 22, F_LBU = 21, F_LHU = 20, F_SB = 19, F_SH = 18, F_SW = 17,
    F_CSRRW = 16, F_CSRRS = 15, F_CSRRC = 14, F_CSRRWI = 13, F_CSRRSI = 12, F_CSRRCI = 11,
    F_SRET = 10, F_WFI = 9, F_MRET = 8, F_ECALL = 7, F_EBREAK = 6,
    F_JALR = 5, F_JAL = 4, F_AUIPC = 3, F_LUI = 2, F_SRA = 1, F_SRL = 0;

  localparam logic [6:0]
    OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
    OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
    OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011,
    OPC_FENCE = 7'b0001111, OPC_SYSTEM = 7'b1110011;

  localparam int unsigned PW = 2 * XLEN + FLAG_W + 16;

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm12;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt, zimm;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign f3     = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign f7     = in_instr[31:25];
  assign imm12  = in_instr[31:20];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign shamt  = {27'b0, in_instr[24:20]};
  assign zimm   = {27'b0, in_instr[19:15]};

  logic [47:0]       base_flags;
  logic [31:0]       imm32;
  logic              dec_illegal;
  logic [FLAG_W-1:0] dec_flags;
  logic [XLEN-1:0]   dec_imm;

  always_comb begin
    base_flags  = '0;
    imm32       = '0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_LUI:   begin base_flags[F_LUI] = 1'b1;   imm32 = imm_u; end
      OPC_AUIPC: begin base_flags[F_AUIPC] = 1'b1; imm32 = imm_u; end
      OPC_JAL:   begin base_flags[F_JAL] = 1'b1;   imm32 = imm_j; end
      OPC_JALR:  begin base_flags[F_JALR] = 1'b1;  imm32 = imm_i; end
      OPC_FENCE: ;
      OPC_BRANCH: begin
        imm32 = imm_b;
        case (f3)
          3'b000:  base_flags[F_BEQ]  = 1'b1;
          3'b001:  base_flags[F_BNE]  = 1'b1;
          3'b100:  base_flags[F_BLT]  = 1'b1;
          3'b101:  base_flags[F_BGE]  = 1'b1;
          3'b110:  base_flags[F_BLTU] = 1'b1;
          3'b111:  base_flags[F_BGEU] = 1'b1;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        imm32 = imm_i;
        case (f3)
          3'b000:  base_flags[F_LB]  = 1'b1;
          3'b001:  base_flags[F_LH]  = 1'b1;
          3'b010:  base_flags[F_LW]  = 1'b1;
          3'b100:  base_flags[F_LBU] = 1'b1;
          3'b101:  base_flags[F_LHU] = 1'b1;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        imm32 = imm_s;
        case (f3)
          3'b000:  base_flags[F_SB] = 1'b1;
          3'b001:  base_flags[F_SH] = 1'b1;
          3'b010:  base_flags[F_SW] = 1'b1;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        imm32 = imm_i;
        case (f3)
          3'b000: base_flags[F_ADDI]  = 1'b1;
          3'b010: base_flags[F_SLTI]  = 1'b1;
          3'b011: base_flags[F_SLTIU] = 1'b1;
          3'b100: base_flags[F_XORI]  = 1'b1;
          3'b110: base_flags[F_ORI]   = 1'b1;
          3'b111: base_flags[F_ANDI]  = 1'b1;
          3'b001: begin
            imm32 = shamt;
            if (f7 == 7'b0000000) base_flags[F_SLLI] = 1'b1;
            else dec_illegal = 1'b1;
          end
          3'b101: begin
            imm32 = shamt;
            if (f7 == 7'b0000000) base_flags[F_SRLI] = 1'b1;
            else if (f7 == 7'b0100000) base_flags[F_SRAI] = 1'b1;
            else dec_illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: base_flags[F_ADD]  = 1'b1;
            3'b001: base_flags[F_SLL]  = 1'b1;
            3'b010: base_flags[F_SLT]  = 1'b1;
            3'b011: base_flags[F_SLTU] = 1'b1;
            3'b100: base_flags[F_XOR]  = 1'b1;
            3'b101: base_flags[F_SRL]  = 1'b1;
            3'b110: base_flags[F_OR]   = 1'b1;
            3'b111: base_flags[F_AND]  = 1'b1;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) base_flags[F_SUB] = 1'b1;
        else if (f7 == 7'b0100000 && f3 == 3'b101) base_flags[F_SRA] = 1'b1;
        else if (!(f7 == 7'b0000001 && EN_MEXT != 0)) dec_illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        imm32 = imm_i;
        if (f3 == 3'b000) begin
          if (rd != 5'd0 || rs1 != 5'd0) dec_illegal = 1'b1;
          else begin
            case (imm12)
              12'h000: base_flags[F_ECALL]  = 1'b1;
              12'h001: base_flags[F_EBREAK] = 1'b1;
              12'h102: base_flags[F_SRET]   = 1'b1;
              12'h105: base_flags[F_WFI]    = 1'b1;
              12'h302: base_flags[F_MRET]   = 1'b1;
              default: dec_illegal = 1'b1;
            endcase
          end
        end else if (EN_CSR == 0) dec_illegal = 1'b1;
        else begin
          case (f3)
            3'b001:  base_flags[F_CSRRW] = 1'b1;
            3'b010:  base_flags[F_CSRRS] = 1'b1;
            3'b011:  base_flags[F_CSRRC] = 1'b1;
            3'b101:  begin base_flags[F_CSRRWI] = 1'b1; imm32 = zimm; end
            3'b110:  begin base_flags[F_CSRRSI] = 1'b1; imm32 = zimm; end
            3'b111:  begin base_flags[F_CSRRCI] = 1'b1; imm32 = zimm; end
            default: dec_illegal = 1'b1;
          endcase
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      base_flags = '0;
      imm32      = '0;
    end
  end

  if (EN_MEXT != 0) begin : g_mext
    logic [7:0] m_flags;
    always_comb begin
      m_flags = '0;
      if (opcode == OPC_OP && f7 == 7'b0000001) m_flags[f3] = 1'b1;
    end
    assign dec_flags = {m_flags, base_flags};
  end else begin : g_base
    assign dec_flags = base_flags;
  end

  assign dec_imm = XLEN'($signed(imm32));

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} fill_e;
  fill_e         state_q, state_d;
  logic [PW-1:0] head_q, tail_q, dec_payload;
  logic          accept, consume, head_from_in, head_from_tail, tail_load;

  assign dec_payload = {in_pc, dec_flags, rd, rs1, rs2, dec_imm, dec_illegal};
  assign {out_pc, out_flags, out_rd, out_rs1, out_rs2, out_imm, out_illegal} = head_q;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (SKID != 0) ? (state_q != TWO) : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign consume   = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // TWO is only reachable with SKID=1, where in_ready is low, so no accept there.
  always_comb begin
    state_d        = state_q;
    head_from_in   = 1'b0;
    head_from_tail = 1'b0;
    tail_load      = 1'b0;
    if (flush) state_d = EMPTY;
    else begin
      case (state_q)
        EMPTY: if (accept) begin state_d = ONE; head_from_in = 1'b1; end
        ONE: begin
          case ({accept, consume})
            2'b11:   head_from_in = 1'b1;
            2'b10:   begin state_d = TWO; tail_load = 1'b1; end
            2'b01:   state_d = EMPTY;
            default: ;
          endcase
        end
        TWO: if (consume) begin head_from_tail = 1'b1; state_d = ONE; end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (head_from_in)        head_q <= dec_payload;
      else if (head_from_tail) head_q <= tail_q;
      if (tail_load)           tail_q <= dec_payload;
    end
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: decode vectors, skid ordering, flush,
// asynchronous reset, and M-extension decode on a second instance.
module tb_rv_decode_stage;
  logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [47:0] out_flags;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        m_in_ready, m_out_valid, m_out_illegal;
  logic [31:0] m_out_pc, m_out_imm;
  logic [55:0] m_out_flags;
  logic [4:0]  m_out_rd, m_out_rs1, m_out_rs2;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(32), .EN_CSR(1), .EN_MEXT(0), .SKID(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_flags(out_flags), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  rv_decode_stage #(.XLEN(32), .EN_CSR(1), .EN_MEXT(1), .SKID(1)) dut_m (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_pc(m_out_pc), .out_flags(m_out_flags), .out_rd(m_out_rd), .out_rs1(m_out_rs1),
    .out_rs2(m_out_rs2), .out_imm(m_out_imm), .out_illegal(m_out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    int          fbit;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (out_pc !== 32'h0 || out_imm !== 32'h0 || out_flags !== 48'h0)
      begin failures++; $display("FAIL reset_payload pc=%h imm=%h flags=%h exp all 0", out_pc, out_imm, out_flags); end
    checks++; if (out_rd !== 5'd0 || out_rs1 !== 5'd0 || out_rs2 !== 5'd0 || out_illegal !== 1'b0)
      begin failures++; $display("FAIL reset_fields rd=%0d rs1=%0d rs2=%0d ill=%b exp 0", out_rd, out_rs1, out_rs2, out_illegal); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_decode();
    vec_t v[14];
    logic [47:0] ef;
    v[0]  = '{32'h00500093, 41, 5'd1,  5'd0,  5'd5,  32'h00000005, 1'b0}; // addi x1,x0,5
    v[1]  = '{32'hFE000EE3, 42, 5'd29, 5'd0,  5'd0,  32'hFFFFFFFC, 1'b0}; // beq x0,x0,-4
    v[2]  = '{32'h123452B7, 2,  5'd5,  5'd8,  5'd3,  32'h12345000, 1'b0}; // lui
    v[3]  = '{32'h0020A423, 17, 5'd8,  5'd1,  5'd2,  32'h00000008, 1'b0}; // sw
    v[4]  = '{32'h40725193, 33, 5'd3,  5'd4,  5'd7,  32'h00000007, 1'b0}; // srai
    v[5]  = '{32'h300AD0F3, 13, 5'd1,  5'd21, 5'd0,  32'h00000015, 1'b0}; // csrrwi
    v[6]  = '{32'h00000073, 7,  5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0}; // ecall
    v[7]  = '{32'h0FF0000F, -1, 5'd0,  5'd0,  5'd31, 32'h00000000, 1'b0}; // fence
    v[8]  = '{32'h00000000, -1, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
    v[9]  = '{32'h40001033, -1, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
    v[10] = '{32'h002081B3, 32, 5'd3,  5'd1,  5'd2,  32'h00000000, 1'b0}; // add
    v[11] = '{32'h000000F3, -1, 5'd1,  5'd0,  5'd0,  32'h00000000, 1'b1}; // ecall, rd!=0
    v[12] = '{32'hFF9FF06F, 4,  5'd0,  5'd31, 5'd25, 32'hFFFFFFF8, 1'b0}; // jal x0,-8
    v[13] = '{32'h02208033, -1, 5'd0,  5'd1,  5'd2,  32'h00000000, 1'b1}; // mul w/o M
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      in_instr = v[i].instr;
      in_pc    = (i == 1) ? 32'h100 : 32'h1000 + 32'(4 * i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      ef = (v[i].fbit < 0) ? 48'h0 : (48'h1 << v[i].fbit);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL dec%0d valid got=%b exp=1", i, out_valid); end
      checks++; if (out_pc !== in_pc) begin failures++; $display("FAIL dec%0d pc got=%h exp=%h", i, out_pc, in_pc); end
      checks++; if (out_flags !== ef) begin failures++; $display("FAIL dec%0d flags got=%h exp=%h", i, out_flags, ef); end
      checks++; if (out_illegal !== v[i].ill) begin failures++; $display("FAIL dec%0d illegal got=%b exp=%b", i, out_illegal, v[i].ill); end
      checks++; if (out_rd !== v[i].rd || out_rs1 !== v[i].rs1 || out_rs2 !== v[i].rs2)
        begin failures++; $display("FAIL dec%0d regs got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, out_rd, out_rs1, out_rs2, v[i].rd, v[i].rs1, v[i].rs2); end
      if (!v[i].ill) begin
        checks++; if (out_imm !== v[i].imm) begin failures++; $display("FAIL dec%0d imm got=%h exp=%h", i, out_imm, v[i].imm); end
      end
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dec_drain valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h200;
    @(posedge clk); #1;
    in_instr = 32'h00200093; in_pc = 32'h204;
    @(posedge clk); #1;
    in_instr = 32'h00300093; in_pc = 32'h208;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_held_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200)
      begin failures++; $display("FAIL b2b_A valid=%b pc=%h exp 1/200", out_valid, out_pc); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h204 || out_imm !== 32'd2)
      begin failures++; $display("FAIL b2b_B valid=%b pc=%h imm=%h exp 1/204/2", out_valid, out_pc, out_imm); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_one_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h208 || out_imm !== 32'd3)
      begin failures++; $display("FAIL b2b_C valid=%b pc=%h imm=%h exp 1/208/3", out_valid, out_pc, out_imm); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty valid got=%b exp=0", out_valid); end
    checks++; if (out_pc !== 32'h208) begin failures++; $display("FAIL b2b_hold pc got=%h exp=208", out_pc); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h300;
    @(posedge clk); #1;
    in_pc = 32'h304;
    @(posedge clk); #1;
    flush = 1'b1; in_instr = 32'h00700093; in_pc = 32'h30C;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush2_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush2_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush2_after got=%b exp=0", out_valid); end
    in_valid = 1'b1; in_pc = 32'h310;
    @(posedge clk); #1;
    flush = 1'b1; in_pc = 32'h314;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush1_valid got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush1_dropped got=%b exp=0", out_valid); end
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h318;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h318)
      begin failures++; $display("FAIL flush_resume valid=%b pc=%h exp 1/318", out_valid, out_pc); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h400;
    @(posedge clk); #1;
    in_pc = 32'h404;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
      begin failures++; $display("FAIL arst_pre valid=%b ready=%b exp 1/0", out_valid, in_ready); end
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b exp=1", in_ready); end
    checks++; if (out_pc !== 32'h0 || out_imm !== 32'h0 || out_flags !== 48'h0)
      begin failures++; $display("FAIL arst_payload pc=%h imm=%h flags=%h exp all 0", out_pc, out_imm, out_flags); end
    checks++; if (out_rd !== 5'd0 || out_rs2 !== 5'd0 || out_illegal !== 1'b0)
      begin failures++; $display("FAIL arst_fields rd=%0d rs2=%0d ill=%b exp 0", out_rd, out_rs2, out_illegal); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_after got=%b exp=0", out_valid); end
  endtask

  task automatic test_mext();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h02208033; in_pc = 32'h500;
    @(posedge clk); #1;
    in_instr = 32'h0220B033; in_pc = 32'h504;
    checks++; if (out_illegal !== 1'b1 || out_flags !== 48'h0)
      begin failures++; $display("FAIL mul_nom ill=%b flags=%h exp 1/0", out_illegal, out_flags); end
    checks++; if (m_out_valid !== 1'b1 || m_in_ready !== 1'b1)
      begin failures++; $display("FAIL mul_hs valid=%b ready=%b exp 1/1", m_out_valid, m_in_ready); end
    checks++; if (m_out_flags !== (56'h1 << 48) || m_out_illegal !== 1'b0)
      begin failures++; $display("FAIL mul_m flags=%h ill=%b exp %h/0", m_out_flags, m_out_illegal, 56'h1 << 48); end
    checks++; if (m_out_pc !== 32'h500 || m_out_imm !== 32'h0)
      begin failures++; $display("FAIL mul_m pc=%h imm=%h exp 500/0", m_out_pc, m_out_imm); end
    checks++; if (m_out_rd !== 5'd0 || m_out_rs1 !== 5'd1 || m_out_rs2 !== 5'd2)
      begin failures++; $display("FAIL mul_m regs %0d/%0d/%0d exp 0/1/2", m_out_rd, m_out_rs1, m_out_rs2); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (m_out_flags !== (56'h1 << 51) || m_out_illegal !== 1'b0)
      begin failures++; $display("FAIL mulhu_m flags=%h ill=%b exp %h/0", m_out_flags, m_out_illegal, 56'h1 << 51); end
    checks++; if (out_illegal !== 1'b1) begin failures++; $display("FAIL mulhu_nom ill got=%b exp=1", out_illegal); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_mext();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
